// File: rtl/can_tx_frame_fetch_if.sv
// FIFO read port plus the frame handshake towards the CAN Tx bit engine.
// master = the frame fetcher, slave = the FIFO / Tx engine side.
interface can_tx_frame_fetch_if #(
    parameter int DATA_WIDTH = 128
);
    logic                  o_fifo_r_en;
    logic [DATA_WIDTH-1:0] i_fifo_r_data;
    logic                  i_fifo_empty;
    logic                  i_fifo_underflow;
    logic                  o_tx_req;
    logic                  i_tx_ack;
    logic [28:0]           o_tx_id;
    logic                  o_tx_ide;
    logic                  o_tx_rtr;
    logic [3:0]            o_tx_dlc;
    logic [63:0]           o_tx_data;
    logic                  i_tx_done;
    logic                  i_tx_arb_lost;
    logic                  i_tx_error;

    modport master (
        output o_fifo_r_en, o_tx_req, o_tx_id, o_tx_ide, o_tx_rtr, o_tx_dlc, o_tx_data,
        input  i_fifo_r_data, i_fifo_empty, i_fifo_underflow,
        input  i_tx_ack, i_tx_done, i_tx_arb_lost, i_tx_error
    );

    modport slave (
        input  o_fifo_r_en, o_tx_req, o_tx_id, o_tx_ide, o_tx_rtr, o_tx_dlc, o_tx_data,
        output i_fifo_r_data, i_fifo_empty, i_fifo_underflow,
        output i_tx_ack, i_tx_done, i_tx_arb_lost, i_tx_error
    );
endinterface

// File: rtl/can_tx_frame_fetch.sv
// Pops one CAN frame at a time from the 128-bit Tx FIFO, unpacks it and offers it to the
// Tx bit engine with bounded error retry. Define CAN_TX_TIMESTAMP_EN for o_tx_timestamp.
module can_tx_frame_fetch #(
    parameter int DATA_WIDTH  = 128,
    parameter int MAX_RETRIES = 3,
    parameter int RETRY_W     = 4
) (
    input  logic                 i_sys_clk,
    input  logic                 i_reset,
    input  logic                 i_enable,
    input  logic                 i_abort,
    can_tx_frame_fetch_if.master bus,
    output logic                 o_busy,
    output logic                 o_frame_sent,
    output logic                 o_frame_dropped,
    output logic [RETRY_W-1:0]   o_retry_cnt
`ifdef CAN_TX_TIMESTAMP_EN
    ,
    output logic [31:0]          o_tx_timestamp
`endif
);
    typedef enum logic [2:0] {IDLE, POP, LOAD, REQ, ACTIVE} state_t;

    localparam logic [RETRY_W:0] RETRY_LIMIT = (RETRY_W+1)'(MAX_RETRIES);

    state_t           state, state_n;
    logic             sent_n, drop_n, load_n, inc_n;
    logic             abort_lat, abort_seen, retry_exhausted;
    logic [RETRY_W:0] retry_inc;
    logic [3:0]       dlc_raw, dlc_clamped;
    logic             unused_pad;

    // Bits 92:64 of the FIFO word carry no frame field.
    assign unused_pad      = ^bus.i_fifo_r_data[92:64];
    assign dlc_raw         = bus.i_fifo_r_data[96:93];
    assign dlc_clamped     = (dlc_raw > 4'd8) ? 4'd8 : dlc_raw;
    assign retry_inc       = {1'b0, o_retry_cnt} + (RETRY_W+1)'(1);
    assign retry_exhausted = retry_inc >= RETRY_LIMIT;
    assign abort_seen      = abort_lat | i_abort;

    always_comb begin
        state_n = state;
        sent_n  = 1'b0;
        drop_n  = 1'b0;
        load_n  = 1'b0;
        inc_n   = 1'b0;
        case (state)
            IDLE: if (i_enable && !bus.i_fifo_empty) state_n = POP;
            POP:  state_n = LOAD;
            LOAD: begin
                if (bus.i_fifo_underflow) begin
                    drop_n  = 1'b1;
                    state_n = IDLE;
                end else begin
                    load_n  = 1'b1;
                    state_n = REQ;
                end
            end
            // Ack beats a same-cycle abort: the engine has already started SOF.
            REQ: begin
                if (bus.i_tx_ack) begin
                    state_n = ACTIVE;
                end else if (i_abort) begin
                    drop_n  = 1'b1;
                    state_n = IDLE;
                end
            end
            ACTIVE: begin
                if (bus.i_tx_done) begin
                    sent_n  = 1'b1;
                    state_n = IDLE;
                end else if (bus.i_tx_error) begin
                    if (retry_exhausted || abort_seen) begin
                        drop_n  = 1'b1;
                        state_n = IDLE;
                    end else begin
                        inc_n   = 1'b1;
                        state_n = REQ;
                    end
                end else if (bus.i_tx_arb_lost) begin
                    if (abort_seen) begin
                        drop_n  = 1'b1;
                        state_n = IDLE;
                    end else begin
                        state_n = REQ;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge i_sys_clk) begin
        if (i_reset) begin
            state           <= IDLE;
            abort_lat       <= 1'b0;
            bus.o_fifo_r_en <= 1'b0;
            bus.o_tx_req    <= 1'b0;
            bus.o_tx_id     <= '0;
            bus.o_tx_ide    <= 1'b0;
            bus.o_tx_rtr    <= 1'b0;
            bus.o_tx_dlc    <= '0;
            bus.o_tx_data   <= '0;
            o_busy          <= 1'b0;
            o_frame_sent    <= 1'b0;
            o_frame_dropped <= 1'b0;
            o_retry_cnt     <= '0;
        end else begin
            state           <= state_n;
            bus.o_fifo_r_en <= (state_n == POP);
            bus.o_tx_req    <= (state_n == REQ);
            o_busy          <= (state_n != IDLE);
            o_frame_sent    <= sent_n;
            o_frame_dropped <= drop_n;
            // Abort is only remembered for the frame currently on the bus.
            abort_lat       <= (state == ACTIVE) && (state_n == ACTIVE) && abort_seen;
            if (load_n) begin
                bus.o_tx_id   <= bus.i_fifo_r_data[127:99];
                bus.o_tx_ide  <= bus.i_fifo_r_data[98];
                bus.o_tx_rtr  <= bus.i_fifo_r_data[97];
                bus.o_tx_dlc  <= dlc_clamped;
                bus.o_tx_data <= bus.i_fifo_r_data[63:0];
                o_retry_cnt   <= '0;
            end else if (inc_n) begin
                o_retry_cnt   <= o_retry_cnt + RETRY_W'(1);
            end
        end
    end

`ifdef CAN_TX_TIMESTAMP_EN
    logic [31:0] cycle_cnt;

    always_ff @(posedge i_sys_clk) begin
        if (i_reset) begin
            cycle_cnt      <= '0;
            o_tx_timestamp <= '0;
        end else begin
            cycle_cnt <= cycle_cnt + 32'd1;
            if (sent_n) o_tx_timestamp <= cycle_cnt;
        end
    end
`endif
endmodule
